snake_mover: RTL and testbench

SNAKE_MOVER -- requirements
Module: snake_mover

---
 rtl/snake_mover.sv | 191 +++++++++++++++++++
 tb/tb_snake_mover.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_mover.sv
// snake_mover: keeps the snake body on a grid, advances it once per tick,
// detects wall and self collisions, and answers per-cell render queries.
module snake_mover #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] direction,
  input  logic       start,
  input  logic       grow,
  input  logic [4:0] query_x,
  input  logic [4:0] query_y,
  output logic       query_hit,
  output logic       query_head,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       step,
  output logic       game_over
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [4:0] X_MAX = 5'(GRID_W - 1);
  localparam logic [4:0] Y_MAX = 5'(GRID_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t     state;
  logic [4:0] seg_x [MAX_LEN];
  logic [4:0] seg_y [MAX_LEN];
  logic [1:0] heading;
  logic [CNT_W-1:0] cnt;
  logic       grow_pending;

  logic       tick;
  logic       reverse;
  logic [1:0] new_heading;
  logic [4:0] next_x;
  logic [4:0] next_y;
  logic       wall_hit;
  logic       self_hit;
  logic       collide;
  logic       reinit;
  logic       hit_any;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  // Next-head calculation and collision detection for the pending move
  always_comb begin
    tick        = (state == RUN) && (cnt == CNT_MAX);
    // Opposite headings share bit 1 and differ in bit 0
    reverse     = (direction[1] == heading[1]) && (direction[0] != heading[0]);
    new_heading = reverse ? heading : direction;
    next_x      = seg_x[0];
    next_y      = seg_y[0];
    wall_hit    = 1'b0;
    unique case (new_heading)
      DIR_UP: begin
        wall_hit = (seg_y[0] == 5'd0);
        next_y   = seg_y[0] - 5'd1;
      end
      DIR_DOWN: begin
        wall_hit = (seg_y[0] >= Y_MAX);
        next_y   = seg_y[0] + 5'd1;
      end
      DIR_LEFT: begin
        wall_hit = (seg_x[0] == 5'd0);
        next_x   = seg_x[0] - 5'd1;
      end
      DIR_RIGHT: begin
        wall_hit = (seg_x[0] >= X_MAX);
        next_x   = seg_x[0] + 5'd1;
      end
      default: wall_hit = 1'b0;
    endcase
    // The tail cell vacates during the move unless the snake is growing
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((seg_x[i] == next_x) && (seg_y[i] == next_y)) begin
        if (i + 1 < int'(length)) begin
          self_hit = 1'b1;
        end else if ((i + 1 == int'(length)) && grow_pending) begin
          self_hit = 1'b1;
        end
      end
    end
    collide = wall_hit || self_hit;
    reinit  = reset || ((state == OVER) && start);
  end

  // Render query match against the active segments only
  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(length)) && (seg_x[i] == query_x) && (seg_y[i] == query_y)) begin
        hit_any = 1'b1;
      end
    end
  end

  // Registered query results
  always_ff @(posedge clk) begin
    if (reset) begin
      query_hit  <= 1'b0;
      query_head <= 1'b0;
    end else begin
      query_hit  <= hit_any;
      query_head <= (seg_x[0] == query_x) && (seg_y[0] == query_y);
    end
  end

  // Game FSM, tick counter, body shift and growth bookkeeping
  always_ff @(posedge clk) begin
    if (reinit) begin
      state     <= IDLE;
      heading   <= DIR_RIGHT;
      cnt       <= '0;
      length    <= 5'd3;
      step      <= 1'b0;
      game_over <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= 5'd0;
        seg_y[i] <= 5'd0;
      end
      seg_x[0] <= 5'd16;
      seg_y[0] <= 5'd12;
      seg_x[1] <= 5'd15;
      seg_y[1] <= 5'd12;
      seg_x[2] <= 5'd14;
      seg_y[2] <= 5'd12;
      // A restart still honours a grow pulse arriving in the same cycle
      grow_pending <= reset ? 1'b0 : grow;
    end else begin
      step <= 1'b0;
      if (grow) begin
        grow_pending <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= tick ? '0 : cnt + CNT_W'(1);
          if (tick) begin
            if (collide) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
              end
              seg_x[0] <= next_x;
              seg_y[0] <= next_y;
              heading  <= new_heading;
              step     <= 1'b1;
              if (grow_pending) begin
                if (length < 5'(MAX_LEN)) begin
                  length <= length + 5'd1;
                end
                // A grow arriving on this step is held for the next one
                grow_pending <= grow;
              end
            end
          end
        end
        OVER: begin
          cnt <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover with a short tick period.
module tb_snake_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] direction = 2'b11;
  logic       start = 1'b0;
  logic       grow = 1'b0;
  logic [4:0] query_x = 5'd0;
  logic [4:0] query_y = 5'd0;
  logic       query_hit;
  logic       query_head;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [4:0] length;
  logic       step;
  logic       game_over;

  snake_mover #(
    .GRID_W  (32),
    .GRID_H  (24),
    .MAX_LEN (16),
    .TICK_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .direction (direction),
    .start     (start),
    .grow      (grow),
    .query_x   (query_x),
    .query_y   (query_y),
    .query_hit (query_hit),
    .query_head(query_head),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .step      (step),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Expected {head_x, head_y, length} per step, and {hit, head} per query
  logic [14:0] exp_mv[$];
  logic [1:0]  exp_qr[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] d);
    direction = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for a step pulse; a timeout counts as a failed comparison
  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step && cyc < 40);
    if (!step) begin
      total++;
      $display("FAIL step_timeout: no step within %0d cycles", cyc);
      cyc = -1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({head_x, head_y, length} !== {5'd16, 5'd12, 5'd3})
      $display("FAIL reset_snake: got (%0d,%0d) len %0d want (16,12) len 3", head_x, head_y, length);
    else passed++;
    total++;
    if ({step, game_over, query_hit, query_head} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {step, game_over, query_hit, query_head});
    else passed++;
  endtask

  task automatic test_query();
    logic [4:0] qx [4] = '{5'd14, 5'd16, 5'd0, 5'd13};
    logic [4:0] qy [4] = '{5'd12, 5'd12, 5'd0, 5'd12};
    logic [1:0] qe [4] = '{2'b10, 2'b11, 2'b00, 2'b00};
    logic [1:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      query_x = qx[i];
      query_y = qy[i];
      exp_qr.push_back(qe[i]);
      @(negedge clk);
      e = exp_qr.pop_front();
      total++;
      if ({query_hit, query_head} !== e)
        $display("FAIL query_%0d: got %b want %b", i, {query_hit, query_head}, e);
      else passed++;
    end
  endtask

  task automatic test_first_step();
    int cyc;
    logic [14:0] e;
    do_reset();
    pulse_start(2'b11);
    exp_mv.push_back({5'd17, 5'd12, 5'd3});
    wait_step(cyc);
    total++;
    if (cyc !== 4) $display("FAIL first_step_latency: got %0d want 4", cyc);
    else passed++;
    e = exp_mv.pop_front();
    total++;
    if ({head_x, head_y, length} !== e)
      $display("FAIL first_step_head: got %h want %h", {head_x, head_y, length}, e);
    else passed++;
    @(negedge clk);
    total++;
    if (step !== 1'b0) $display("FAIL step_width: got %b want 0", step);
    else passed++;
  endtask

  task automatic test_reverse();
    int cyc;
    logic [14:0] e;
    direction = 2'b10;
    for (int k = 0; k < 2; k++) begin
      exp_mv.push_back({5'(18 + k), 5'd12, 5'd3});
      wait_step(cyc);
      e = exp_mv.pop_front();
      total++;
      if ({head_x, head_y, length} !== e)
        $display("FAIL reverse_ignored_%0d: got %h want %h", k, {head_x, head_y, length}, e);
      else passed++;
    end
    direction = 2'b11;
  endtask

  task automatic test_grow();
    int cyc;
    logic [14:0] e;
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    exp_mv.push_back({5'd20, 5'd12, 5'd4});
    wait_step(cyc);
    e = exp_mv.pop_front();
    total++;
    if ({head_x, head_y, length} !== e)
      $display("FAIL grow_one: got %h want %h", {head_x, head_y, length}, e);
    else passed++;
    // Grow sampled on the tick edge must not apply to that step
    repeat (3) @(negedge clk);
    grow = 1'b1;
    exp_mv.push_back({5'd21, 5'd12, 5'd4});
    @(negedge clk);
    grow = 1'b0;
    e = exp_mv.pop_front();
    total++;
    if ({step, head_x, head_y, length} !== {1'b1, e})
      $display("FAIL grow_coincide: got %h want %h", {step, head_x, head_y, length}, {1'b1, e});
    else passed++;
    exp_mv.push_back({5'd22, 5'd12, 5'd5});
    wait_step(cyc);
    e = exp_mv.pop_front();
    total++;
    if ({head_x, head_y, length} !== e)
      $display("FAIL grow_deferred: got %h want %h", {head_x, head_y, length}, e);
    else passed++;
  endtask

  task automatic test_self_collision();
    int cyc;
    logic [14:0] e;
    bit saw_step;
    direction = 2'b00;
    exp_mv.push_back({5'd22, 5'd11, 5'd5});
    wait_step(cyc);
    e = exp_mv.pop_front();
    total++;
    if ({head_x, head_y, length} !== e)
      $display("FAIL turn_up: got %h want %h", {head_x, head_y, length}, e);
    else passed++;
    direction = 2'b10;
    exp_mv.push_back({5'd21, 5'd11, 5'd5});
    wait_step(cyc);
    e = exp_mv.pop_front();
    total++;
    if ({head_x, head_y, length} !== e)
      $display("FAIL turn_left: got %h want %h", {head_x, head_y, length}, e);
    else passed++;
    direction = 2'b01;
    saw_step = 1'b0;
    for (int i = 0; i < 10 && !game_over; i++) begin
      @(negedge clk);
      if (step) saw_step = 1'b1;
    end
    total++;
    if (game_over !== 1'b1 || saw_step)
      $display("FAIL self_collision: game_over %b step_seen %b want 1 0", game_over, saw_step);
    else passed++;
    total++;
    if ({head_x, head_y, length} !== {5'd21, 5'd11, 5'd5})
      $display("FAIL self_collision_frozen: got (%0d,%0d) len %0d want (21,11) len 5",
               head_x, head_y, length);
    else passed++;
    pulse_start(2'b11);
    total++;
    if ({game_over, head_x, head_y, length} !== {1'b0, 5'd16, 5'd12, 5'd3})
      $display("FAIL restart_snake: got go %b (%0d,%0d) len %0d want 0 (16,12) 3",
               game_over, head_x, head_y, length);
    else passed++;
    saw_step = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (step) saw_step = 1'b1;
    end
    total++;
    if (saw_step) $display("FAIL restart_idle: got step in IDLE want none");
    else passed++;
  endtask

  task automatic test_max_len();
    int cyc;
    logic [14:0] e;
    pulse_start(2'b11);
    for (int k = 1; k <= 14; k++) begin
      grow = 1'b1;
      @(negedge clk);
      grow = 1'b0;
      exp_mv.push_back({5'(16 + k), 5'd12, 5'((3 + k > 16) ? 16 : 3 + k)});
      wait_step(cyc);
      e = exp_mv.pop_front();
      total++;
      if ({head_x, head_y, length} !== e)
        $display("FAIL max_len_%0d: got %h want %h", k, {head_x, head_y, length}, e);
      else passed++;
    end
  endtask

  task automatic test_wall();
    int cyc;
    logic [14:0] e;
    bit saw_step;
    do_reset();
    pulse_start(2'b00);
    for (int k = 1; k <= 12; k++) begin
      exp_mv.push_back({5'd16, 5'(12 - k), 5'd3});
      wait_step(cyc);
      e = exp_mv.pop_front();
      total++;
      if ({head_x, head_y, length} !== e)
        $display("FAIL wall_up_%0d: got %h want %h", k, {head_x, head_y, length}, e);
      else passed++;
    end
    saw_step = 1'b0;
    for (int i = 0; i < 10 && !game_over; i++) begin
      @(negedge clk);
      if (step) saw_step = 1'b1;
    end
    total++;
    if ({game_over, saw_step, head_x, head_y} !== {1'b1, 1'b0, 5'd16, 5'd0})
      $display("FAIL wall_collision: got go %b step %b (%0d,%0d) want 1 0 (16,0)",
               game_over, saw_step, head_x, head_y);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit saw_step;
    do_reset();
    pulse_start(2'b11);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    grow = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    grow = 1'b0;
    total++;
    if ({step, game_over, head_x, head_y, length} !== {2'b00, 5'd16, 5'd12, 5'd3})
      $display("FAIL reset_mid: got %h want %h", {step, game_over, head_x, head_y, length},
               {2'b00, 5'd16, 5'd12, 5'd3});
    else passed++;
    saw_step = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (step) saw_step = 1'b1;
    end
    total++;
    if (saw_step) $display("FAIL reset_mid_idle: got step want none");
    else passed++;
    pulse_start(2'b11);
    wait_step(cyc);
    total++;
    if ({head_x, head_y, length} !== {5'd17, 5'd12, 5'd3})
      $display("FAIL reset_mid_no_grow: got (%0d,%0d) len %0d want (17,12) len 3",
               head_x, head_y, length);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_query();
    test_first_step();
    test_reverse();
    test_grow();
    test_self_collision();
    test_max_len();
    test_wall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
